// File: rtl/alu_seq_n.sv
// N-bit sequential ALU with valid/ready handshakes and registered result/flags.
// Define ALU_MUL_EN to make op 111 a multi-cycle shift-add multiply; otherwise op 111 is AND.
module alu_seq_n #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  generate
    if (WIDTH < 2 || CNT_W < $clog2(WIDTH) + 1) begin : g_param_check
      $error("alu_seq_n: WIDTH must be >= 2 and CNT_W must not be overridden");
    end
  endgenerate

  logic             accept;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] lres;
  logic             lcout;
  logic             lovf;
  logic             lzero;

  // Single-cycle datapath; op 111 falls to AND, which is what the legacy build needs.
  always_comb begin
    bx    = b ^ {WIDTH{sub}};
    sum   = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
    lcout = 1'b0;
    lovf  = 1'b0;
    case (op)
      3'b000:  lres = ~(a | b);
      3'b001:  lres = ~(a & b);
      3'b010:  lres = a | b;
      3'b011:  lres = a & b;
      3'b100:  lres = a ^ b;
      3'b101:  lres = ~(a ^ b);
      3'b110: begin
        lres  = sum[WIDTH-1:0];
        lcout = sum[WIDTH];
        lovf  = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      default: lres = a & b;
    endcase
    lzero = (lres == '0);
  end

  assign accept = in_valid && in_ready;

`ifdef ALU_MUL_EN

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mpr;
  logic [CNT_W-1:0]   cnt;

  always_comb begin
    case (state)
      IDLE:    in_ready = !out_valid || out_ready;
      HOLD:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    acc_nxt = acc + (mpr[0] ? mcand : '0);
  end

  assign busy = (state == MUL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mpr       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        // IDLE and HOLD share the accept/consume logic; HOLD only differs in in_ready.
        IDLE, HOLD: begin
          if (accept && op == 3'b111) begin
            acc       <= '0;
            mcand     <= {{WIDTH{1'b0}}, a};
            mpr       <= b;
            cnt       <= '0;
            out_valid <= 1'b0;
            state     <= MUL;
          end else if (accept) begin
            result    <= lres;
            cout      <= lcout;
            ovf       <= lovf;
            zero      <= lzero;
            out_valid <= 1'b1;
            state     <= IDLE;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        MUL: begin
          acc   <= acc_nxt;
          mcand <= mcand << 1;
          mpr   <= mpr >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            result    <= acc_nxt[WIDTH-1:0];
            cout      <= |acc_nxt[2*WIDTH-1:WIDTH];
            ovf       <= 1'b0;
            zero      <= (acc_nxt[WIDTH-1:0] == '0);
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  assign in_ready = !out_valid || out_ready;
  assign busy     = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (accept) begin
      result    <= lres;
      cout      <= lcout;
      ovf       <= lovf;
      zero      <= lzero;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_alu_seq_n.sv
// Directed self-checking bench for alu_seq_n at WIDTH=8; multiply tests need ALU_MUL_EN.
module tb_alu_seq_n;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, sub, cin;
  logic         out_valid, out_ready, cout, ovf, zero, busy;
  logic [W-1:0] a, b, result;
  logic [2:0]   op;
  int           n_checks = 0;
  int           n_fail = 0;

  alu_seq_n #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .ovf(ovf), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic s, input logic c);
    in_valid = 1'b1; op = o; a = x; b = y; sub = s; cin = c;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1;
    drive(3'b110, 8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) tick();
    n_checks++;
    if ({out_valid, result, in_ready, busy, cout, ovf, zero} !== {1'b0, 8'h00, 1'b1, 1'b0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset: got %h required %h", {out_valid, result, in_ready, busy, cout, ovf, zero},
               {1'b0, 8'h00, 1'b1, 1'b0, 3'b000});
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_add();
    drive(3'b110, 8'h7F, 8'h01, 1'b0, 1'b0);
    tick(); in_valid = 1'b0;
    n_checks++;
    if ({out_valid, result, cout, ovf, zero} !== {1'b1, 8'h80, 3'b010}) begin
      n_fail++;
      $display("FAIL add_ovf: got %h required %h", {out_valid, result, cout, ovf, zero}, {1'b1, 8'h80, 3'b010});
    end
    tick();
    n_checks++;
    if ({out_valid, result} !== {1'b0, 8'h80}) begin
      n_fail++;
      $display("FAIL consume_keep: got %h required %h", {out_valid, result}, {1'b0, 8'h80});
    end
    drive(3'b110, 8'hFF, 8'h01, 1'b0, 1'b0);
    tick(); in_valid = 1'b0;
    n_checks++;
    if ({out_valid, result, cout, ovf, zero} !== {1'b1, 8'h00, 3'b101}) begin
      n_fail++;
      $display("FAIL add_carry: got %h required %h", {out_valid, result, cout, ovf, zero}, {1'b1, 8'h00, 3'b101});
    end
    tick();
  endtask

  task automatic test_sub();
    drive(3'b110, 8'h05, 8'h07, 1'b1, 1'b1);
    tick(); in_valid = 1'b0;
    n_checks++;
    if ({out_valid, result, cout, ovf, zero} !== {1'b1, 8'hFE, 3'b000}) begin
      n_fail++;
      $display("FAIL sub: got %h required %h", {out_valid, result, cout, ovf, zero}, {1'b1, 8'hFE, 3'b000});
    end
    tick();
  endtask

  task automatic test_logic_stream();
    out_ready = 1'b1;
    drive(3'b000, 8'hF0, 8'h0F, 1'b0, 1'b0);
    tick();
    n_checks++;
    if ({out_valid, result, cout, ovf, zero} !== {1'b1, 8'h00, 3'b001}) begin
      n_fail++;
      $display("FAIL stream_nor: got %h required %h", {out_valid, result, cout, ovf, zero}, {1'b1, 8'h00, 3'b001});
    end
    drive(3'b101, 8'hAA, 8'hAA, 1'b0, 1'b0);
    tick(); in_valid = 1'b0;
    n_checks++;
    if ({out_valid, result, cout, ovf, zero} !== {1'b1, 8'hFF, 3'b000}) begin
      n_fail++;
      $display("FAIL stream_xnor: got %h required %h", {out_valid, result, cout, ovf, zero}, {1'b1, 8'hFF, 3'b000});
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drain: got %b required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    drive(3'b000, 8'hF0, 8'h0F, 1'b0, 1'b0);
    tick();
    out_ready = 1'b0;
    drive(3'b101, 8'hAA, 8'hAA, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_in_ready_low: got %b required 0", in_ready);
    end
    tick(); tick();
    n_checks++;
    if ({out_valid, result, zero} !== {1'b1, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_hold: got %h required %h", {out_valid, result, zero}, {1'b1, 8'h00, 1'b1});
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_in_ready_high: got %b required 1", in_ready);
    end
    tick(); in_valid = 1'b0;
    n_checks++;
    if ({out_valid, result, zero} !== {1'b1, 8'hFF, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_release: got %h required %h", {out_valid, result, zero}, {1'b1, 8'hFF, 1'b0});
    end
    tick();
  endtask

  task automatic test_and();
    drive(3'b011, 8'hC3, 8'h3C, 1'b0, 1'b0);
    tick();
    n_checks++;
    if ({out_valid, result, cout, ovf, zero} !== {1'b1, 8'h00, 3'b001}) begin
      n_fail++;
      $display("FAIL and_zero: got %h required %h", {out_valid, result, cout, ovf, zero}, {1'b1, 8'h00, 3'b001});
    end
    drive(3'b011, 8'hF3, 8'h3F, 1'b0, 1'b0);
    tick(); in_valid = 1'b0;
    n_checks++;
    if ({out_valid, result, zero} !== {1'b1, 8'h33, 1'b0}) begin
      n_fail++;
      $display("FAIL and_value: got %h required %h", {out_valid, result, zero}, {1'b1, 8'h33, 1'b0});
    end
    tick();
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul();
    int cyc, busy_cyc, stray;
    out_ready = 1'b0;
    drive(3'b111, 8'd13, 8'd11, 1'b0, 1'b0);
    tick();
    drive(3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
    cyc = 0; busy_cyc = 0; stray = 0;
    while (!out_valid && cyc < 20) begin
      if (busy) busy_cyc++;
      if (in_ready) stray++;
      if (cyc == 3) in_valid = 1'b0;
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != 8 || busy_cyc != 8 || stray != 0) begin
      n_fail++;
      $display("FAIL mul_latency: got cyc=%0d busy=%0d ready_in_mul=%0d required 8 8 0", cyc, busy_cyc, stray);
    end
    n_checks++;
    if ({out_valid, result, cout, ovf, zero, busy} !== {1'b1, 8'h8F, 4'b0000}) begin
      n_fail++;
      $display("FAIL mul_13x11: got %h required %h", {out_valid, result, cout, ovf, zero, busy}, {1'b1, 8'h8F, 4'b0000});
    end
    tick();
    n_checks++;
    if ({out_valid, result, in_ready} !== {1'b1, 8'h8F, 1'b0}) begin
      n_fail++;
      $display("FAIL mul_hold: got %h required %h", {out_valid, result, in_ready}, {1'b1, 8'h8F, 1'b0});
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_consume: got %b required 0", out_valid);
    end
    drive(3'b111, 8'h10, 8'h10, 1'b0, 1'b0);
    tick(); in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    n_checks++;
    if ({out_valid, result, cout, ovf, zero} !== {1'b1, 8'h00, 3'b101} || cyc != 8) begin
      n_fail++;
      $display("FAIL mul_16x16: got %h cyc=%0d required %h cyc=8", {out_valid, result, cout, ovf, zero}, cyc,
               {1'b1, 8'h00, 3'b101});
    end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    drive(3'b111, 8'hFF, 8'hFF, 1'b0, 1'b0);
    tick(); in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({busy, out_valid, in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_mid_mul: got %b required 001", {busy, out_valid, in_ready});
    end
    seen = 0;
    repeat (10) begin
      tick();
      if (out_valid || busy) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL mul_aborted: got %0d active cycles required 0", seen);
    end
  endtask
`else
  task automatic test_legacy_op7();
    drive(3'b111, 8'hC3, 8'h3C, 1'b0, 1'b0);
    tick();
    n_checks++;
    if ({out_valid, result, cout, ovf, zero, busy} !== {1'b1, 8'h00, 4'b0010}) begin
      n_fail++;
      $display("FAIL op7_and_zero: got %h required %h", {out_valid, result, cout, ovf, zero, busy}, {1'b1, 8'h00, 4'b0010});
    end
    drive(3'b111, 8'hF3, 8'h3F, 1'b0, 1'b0);
    tick(); in_valid = 1'b0;
    n_checks++;
    if ({out_valid, result, zero, busy} !== {1'b1, 8'h33, 2'b00}) begin
      n_fail++;
      $display("FAIL op7_and_value: got %h required %h", {out_valid, result, zero, busy}, {1'b1, 8'h33, 2'b00});
    end
    tick();
  endtask
`endif

  initial begin
    in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
    a = '0; b = '0; op = '0; sub = 1'b0; cin = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_logic_stream();
    test_backpressure();
`ifdef ALU_MUL_EN
    test_mul();
    test_reset_mid_mul();
`else
    test_legacy_op7();
`endif
    test_and();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
